des_iter_core: RTL and testbench

//   Iterative DES encrypt/decrypt engine: 64-bit block, 64-bit key, ROUNDS_PER_CYCLE rounds/clock.

---
 rtl/des_iter_core.sv | 187 ++++++++++++++++++
 tb/tb_des_iter_core.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_iter_core.sv
// rtl/des_iter_core.sv - iterative DES encrypt/decrypt core, ROUNDS_PER_CYCLE rounds per clock
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mode,
    input  logic [63:0] i_key,
    input  logic [63:0] i_text,
    output logic        o_valid,
    input  logic        i_out_ready,
    output logic [63:0] o_text,
    output logic        o_busy
);
    localparam int RPC = ROUNDS_PER_CYCLE;
    localparam logic [3:0] LAST_CNT = 4'(16 - RPC);
    localparam logic [3:0] CNT_STEP = 4'(RPC);

    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each S-box is 64 nibbles, row-major, entry (row 0, col 0) in the top nibble.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    function automatic logic [63:0] f_ip(input logic [63:0] x);
        for (int i = 0; i < 64; i++) f_ip[6'(63 - i)] = x[6'(64 - IP_T[i])];
    endfunction

    function automatic logic [63:0] f_fp(input logic [63:0] x);
        for (int i = 0; i < 64; i++) f_fp[6'(63 - i)] = x[6'(64 - FP_T[i])];
    endfunction

    function automatic logic [47:0] f_e(input logic [31:0] x);
        for (int i = 0; i < 48; i++) f_e[6'(47 - i)] = x[5'(32 - E_T[i])];
    endfunction

    function automatic logic [31:0] f_p(input logic [31:0] x);
        for (int i = 0; i < 32; i++) f_p[5'(31 - i)] = x[5'(32 - P_T[i])];
    endfunction

    function automatic logic [55:0] f_pc1(input logic [63:0] x);
        for (int i = 0; i < 56; i++) f_pc1[6'(55 - i)] = x[6'(64 - PC1_T[i])];
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] x);
        for (int i = 0; i < 48; i++) f_pc2[6'(47 - i)] = x[6'(56 - PC2_T[i])];
    endfunction

    function automatic logic [31:0] f_sbox(input logic [47:0] x);
        logic [5:0]   g6;
        logic [5:0]   idx;
        logic [255:0] tbl;
        f_sbox = '0;
        for (int g = 0; g < 8; g++) begin
            g6  = x[47 - 6*g -: 6];
            idx = {g6[5], g6[0], g6[4:1]};
            tbl = SBOX[g];
            f_sbox[31 - 4*g -: 4] = tbl[8'd255 - {idx, 2'b00} -: 4];
        end
    endfunction

    // Decrypt walks the schedule backwards: right rotations undo the encrypt rotations,
    // and the full 28-bit encrypt cycle means round 1 starts from K16 with no rotation.
    function automatic logic [27:0] f_ks_shift(input logic [27:0] x, input logic [4:0] n, input logic dec);
        logic two;
        two = !(n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16);
        if (!dec)
            f_ks_shift = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
        else if (n == 5'd1)
            f_ks_shift = x;
        else
            f_ks_shift = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [119:0] f_rounds(input logic [119:0] s, input logic [3:0] cnt, input logic dec);
        logic [31:0] l, r, t;
        logic [27:0] c, d;
        logic [4:0]  n;
        {l, r, c, d} = s;
        for (int j = 0; j < RPC; j++) begin
            n = {1'b0, cnt} + 5'(j + 1);
            c = f_ks_shift(c, n, dec);
            d = f_ks_shift(d, n, dec);
            t = l ^ f_p(f_sbox(f_e(r) ^ f_pc2({c, d})));
            l = r;
            r = t;
        end
        f_rounds = {l, r, c, d};
    endfunction

    state_t      r_state;
    logic [31:0] r_l, r_r;
    logic [27:0] r_c, r_d;
    logic [3:0]  r_cnt;
    logic        r_mode;
    logic [63:0] r_text;
    logic        r_valid, r_ready, r_busy;

    logic [31:0] w_l, w_r;
    logic [27:0] w_c, w_d;

    assign {w_l, w_r, w_c, w_d} = f_rounds({r_l, r_r, r_c, r_d}, r_cnt, r_mode);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_l     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_text  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        {r_l, r_r} <= f_ip(i_text);
                        {r_c, r_d} <= f_pc1(i_key);
                        r_mode     <= i_mode;
                        r_cnt      <= '0;
                        r_state    <= S_ROUND;
                        r_ready    <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_l <= w_l;
                    r_r <= w_r;
                    r_c <= w_c;
                    r_d <= w_d;
                    if (r_cnt == LAST_CNT) begin
                        r_text  <= f_fp({w_r, w_l});
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_STEP;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_text  = r_text;
    assign o_busy  = r_busy;
endmodule

// File: tb/tb_des_iter_core.sv
// tb/tb_des_iter_core.sv - self-checking bench for des_iter_core at RPC 1, 2, 4 and 16
module tb_des_iter_core;
    localparam int NI = 4;
    localparam int LAT [NI] = '{17, 9, 5, 2};
    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K3 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P3 = 64'h8787878787878787;
    localparam logic [63:0] PARITY = 64'h0101010101010101;

    // IP @0, FP @64, E @128, P @176, PC1 @208, PC2 @264; entries are 1-based, bit 1 = MSB
    localparam int T_ALL [312] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7,
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25,
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1,
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25,
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4,
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam logic [255:0] SB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0]       i_valid_a = '0;
    logic [NI-1:0]       i_mode_a = '0;
    logic [NI-1:0]       i_out_ready_a = '1;
    logic [NI-1:0][63:0] i_key_a = '0;
    logic [NI-1:0][63:0] i_text_a = '0;
    logic [NI-1:0]       o_ready_a, o_valid_a, o_busy_a;
    logic [NI-1:0][63:0] o_text_a;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        des_iter_core #(.ROUNDS_PER_CYCLE((k == 3) ? 16 : (1 << k))) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_valid    (i_valid_a[k]),
            .o_ready    (o_ready_a[k]),
            .i_mode     (i_mode_a[k]),
            .i_key      (i_key_a[k]),
            .i_text     (i_text_a[k]),
            .o_valid    (o_valid_a[k]),
            .i_out_ready(i_out_ready_a[k]),
            .o_text     (o_text_a[k]),
            .o_busy     (o_busy_a[k])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int off, input int out_w);
        logic [63:0] y = '0;
        for (int i = 0; i < out_w; i++) y[6'(out_w - 1 - i)] = x[6'(in_w - T_ALL[off + i])];
        return y;
    endfunction

    function automatic logic [31:0] feist(input logic [31:0] r, input logic [47:0] k);
        logic [63:0]  ex;
        logic [47:0]  x;
        logic [31:0]  s = '0;
        logic [5:0]   six;
        logic [255:0] tmp;
        int           idx;
        ex = perm({32'b0, r}, 32, 128, 48);
        x  = ex[47:0] ^ k;
        for (int g = 0; g < 8; g++) begin
            six = x[47 - 6*g -: 6];
            idx = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
            tmp = SB[g] >> (4 * (63 - idx));
            s   = {s[27:0], tmp[3:0]};
        end
        ex = perm({32'b0, s}, 32, 176, 32);
        return ex[31:0];
    endfunction

    // Textbook DES: build all sixteen subkeys up front, decrypt just applies them in reverse.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] txt, input bit dec);
        logic [47:0] ks [16];
        logic [63:0] tmp;
        logic [27:0] c, d;
        logic [31:0] l, r, t;
        int          sh;
        tmp = perm(key, 64, 208, 56);
        c = tmp[55:28];
        d = tmp[27:0];
        for (int i = 0; i < 16; i++) begin
            sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
            for (int s = 0; s < sh; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            tmp   = perm({8'b0, c, d}, 56, 264, 48);
            ks[i] = tmp[47:0];
        end
        tmp = perm(txt, 64, 0, 64);
        l = tmp[63:32];
        r = tmp[31:0];
        for (int i = 0; i < 16; i++) begin
            t = l ^ feist(r, ks[dec ? 15 - i : i]);
            l = r;
            r = t;
        end
        return perm({r, l}, 64, 64, 64);
    endfunction

    // Transaction-level expectation per instance: countdown from accept to result, then hold until taken.
    bit          m_ready [NI] = '{default: 1'b1};
    bit          m_valid [NI] = '{default: 1'b0};
    int          m_cd    [NI] = '{default: 0};
    int          m_acc   [NI] = '{default: 0};
    logic [63:0] m_res   [NI] = '{default: 64'h0};
    logic [63:0] m_text  [NI] = '{default: 64'h0};

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_ready[k] = 1'b1;
                m_valid[k] = 1'b0;
                m_text[k]  = '0;
                m_cd[k]    = 0;
            end else if (m_ready[k]) begin
                if (i_valid_a[k]) begin
                    m_ready[k] = 1'b0;
                    m_cd[k]    = 16 / ((k == 3) ? 16 : (1 << k));
                    m_res[k]   = des_ref(i_key_a[k], i_text_a[k], i_mode_a[k]);
                    m_acc[k]++;
                end
            end else if (m_cd[k] > 0) begin
                m_cd[k]--;
                if (m_cd[k] == 0) begin
                    m_valid[k] = 1'b1;
                    m_text[k]  = m_res[k];
                end
            end else if (i_out_ready_a[k]) begin
                m_valid[k] = 1'b0;
                m_ready[k] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("cyc_ready%0d", k), 64'(o_ready_a[k]), 64'(m_ready[k]));
                chk($sformatf("cyc_busy%0d", k), 64'(o_busy_a[k]), 64'(!m_ready[k]));
                chk($sformatf("cyc_valid%0d", k), 64'(o_valid_a[k]), 64'(m_valid[k]));
                chk($sformatf("cyc_text%0d", k), o_text_a[k], m_text[k]);
            end
        end
    end

    task automatic run_block(input int k, input logic [63:0] key, input logic [63:0] txt, input bit dec,
                             input logic [63:0] exp, input string nm);
        int waited;
        @(negedge clk);
        i_valid_a[k] = 1'b1;
        i_key_a[k] = key;
        i_text_a[k] = txt;
        i_mode_a[k] = dec;
        i_out_ready_a[k] = 1'b1;
        @(negedge clk);
        i_valid_a[k] = 1'b0;
        i_key_a[k] = {$urandom, $urandom};
        i_text_a[k] = {$urandom, $urandom};
        i_mode_a[k] = ~dec;
        waited = 1;
        while (o_valid_a[k] !== 1'b1 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        chk({nm, "_lat"}, 64'(waited), 64'(LAT[k]));
        chk({nm, "_text"}, o_text_a[k], exp);
        @(negedge clk);
    endtask

    int w;
    int acc0 [NI];

    initial begin
        chk("model_t1_enc", des_ref(K1, P1, 1'b0), C1);
        chk("model_t2_dec", des_ref(K1, C1, 1'b1), P1);
        chk("model_t3_enc", des_ref(K3, P3, 1'b0), 64'h0);
        chk("model_t3_parity", des_ref(K3 ^ PARITY, P3, 1'b0), 64'h0);

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(o_valid_a), 64'h0);
        chk("rst_busy", 64'(o_busy_a), 64'h0);
        chk("rst_text0", o_text_a[0], 64'h0);
        #2 rst_n = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        chk("rel_ready", 64'(o_ready_a), 64'hF);

        for (int k = 0; k < NI; k++) begin
            run_block(k, K1, P1, 1'b0, C1, $sformatf("t1_rpc%0d", k));
            run_block(k, K1, C1, 1'b1, P1, $sformatf("t2_rpc%0d", k));
        end
        run_block(0, K3, P3, 1'b0, 64'h0, "t3_enc");
        run_block(0, K3 ^ PARITY, P3, 1'b0, 64'h0, "t3_parity");
        run_block(3, K3 ^ PARITY, 64'h0, 1'b1, P3, "t3_dec16");

        @(negedge clk);
        i_out_ready_a[0] = 1'b0;
        i_valid_a[0] = 1'b1;
        i_key_a[0] = K1;
        i_text_a[0] = P1;
        i_mode_a[0] = 1'b0;
        @(negedge clk);
        i_valid_a[0] = 1'b0;
        w = 0;
        while (o_valid_a[0] !== 1'b1 && w < 60) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 64'(o_valid_a[0]), 64'd1);
            chk("bp_text", o_text_a[0], C1);
            chk("bp_ready", 64'(o_ready_a[0]), 64'd0);
            i_valid_a[0] = i[0];
            i_text_a[0] = {$urandom, $urandom};
            @(negedge clk);
        end
        i_valid_a[0] = 1'b0;
        i_out_ready_a[0] = 1'b1;
        @(negedge clk);
        chk("bp_drop", 64'(o_valid_a[0]), 64'd0);
        chk("bp_hold", o_text_a[0], C1);
        chk("bp_ready_back", 64'(o_ready_a[0]), 64'd1);

        @(negedge clk);
        i_valid_a[0] = 1'b1;
        i_key_a[0] = K1;
        i_text_a[0] = P1;
        i_mode_a[0] = 1'b0;
        @(negedge clk);
        i_valid_a[0] = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 64'(o_valid_a[0]), 64'd0);
        chk("mid_rst_text", o_text_a[0], 64'h0);
        chk("mid_rst_ready", 64'(o_ready_a[0]), 64'd1);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", 64'(o_valid_a[0]), 64'd0);
        run_block(0, K1, C1, 1'b1, P1, "t5_dec");

        for (int k = 0; k < NI; k++) acc0[k] = m_acc[k];
        for (int c = 0; c < 2400; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                i_valid_a[k] = ($urandom_range(0, 1) == 1);
                i_key_a[k] = {$urandom, $urandom};
                i_text_a[k] = {$urandom, $urandom};
                i_mode_a[k] = ($urandom_range(0, 1) == 1);
                i_out_ready_a[k] = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        i_valid_a = '0;
        i_out_ready_a = '1;
        repeat (30) @(negedge clk);
        for (int k = 0; k < NI; k++)
            chk($sformatf("rand_blocks%0d", k), 64'(m_acc[k] - acc0[k] >= 30), 64'd1);
        chk("drain_idle", 64'(o_ready_a), 64'hF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
